// File: rtl/main_memory_ctrl.sv
// Backing-store word memory with a fixed-latency sequencer for write-through
// word stores and 4-word block refills; ready pulses once per completed access.
module main_memory_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int BLK_W   = 2,
  parameter int LATENCY = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        mem_read,
  input  logic                        mem_write,
  input  logic                        miss,
  input  logic [ADDR_W-1:0]           addr,
  input  logic [DATA_W-1:0]           wdata,
  output logic                        ready,
  output logic                        busy,
  output logic [(DATA_W<<BLK_W)-1:0]  rdata_block
);

  // state   | meaning
  // S_IDLE  | waiting for a store or a read miss
  // S_WRITE | store accepted, counting down to array commit
  // S_READ  | refill accepted, counting down to block capture
  // S_DONE  | one-cycle turnaround after ready, no request accepted

  localparam int NWORDS = 1 << BLK_W;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]        cnt;
  logic [ADDR_W-1:0]       addr_q;
  logic [DATA_W-1:0]       wdata_q;
  logic [ADDR_W-BLK_W-1:0] blk_q;
  logic [DATA_W-1:0]       mem [DEPTH];

  logic start_wr, start_rd, cnt_dec, wr_commit, rd_commit, finish;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_wr  = 1'b0;
    start_rd  = 1'b0;
    cnt_dec   = 1'b0;
    wr_commit = 1'b0;
    rd_commit = 1'b0;
    finish    = 1'b0;
    case (state)
      S_IDLE: begin
        if (mem_write) begin
          start_wr  = 1'b1;
          state_nxt = S_WRITE;
        end else if (mem_read && miss) begin
          start_rd  = 1'b1;
          state_nxt = S_READ;
        end
      end
      S_WRITE: begin
        if (cnt == '0) begin
          wr_commit = 1'b1;
          state_nxt = S_DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_READ: begin
        if (cnt == '0) begin
          rd_commit = 1'b1;
          state_nxt = S_DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_DONE: begin
        finish    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      blk_q       <= '0;
      ready       <= 1'b0;
      busy        <= 1'b0;
      rdata_block <= '0;
    end else begin
      ready <= wr_commit | rd_commit;
      if (start_wr) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        cnt     <= CNT_W'(LATENCY - 1);
        busy    <= 1'b1;
      end else if (start_rd) begin
        blk_q <= addr[ADDR_W-1:BLK_W];
        cnt   <= CNT_W'(LATENCY - 1);
        busy  <= 1'b1;
      end else if (cnt_dec) begin
        cnt <= cnt - CNT_W'(1);
      end else if (finish) begin
        busy <= 1'b0;
      end
      if (rd_commit) begin
        for (int k = 0; k < NWORDS; k++)
          rdata_block[k*DATA_W +: DATA_W] <= mem[{blk_q, k[BLK_W-1:0]}];
      end
    end
  end

  // Array is deliberately outside the reset domain: contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_commit) mem[addr_q] <= wdata_q;
  end

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Directed self-checking bench for main_memory_ctrl: stores, refills, hit
// filtering, request priority, mid-access changes and reset abort.
module tb_main_memory_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         mem_read, mem_write, miss;
  logic [9:0]   addr;
  logic [31:0]  wdata;
  logic         ready, busy;
  logic [127:0] rdata_block;

  int total = 0;
  int bad   = 0;
  int n;

  main_memory_ctrl dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .miss(miss), .addr(addr), .wdata(wdata), .ready(ready), .busy(busy),
    .rdata_block(rdata_block)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (ready !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  // Accept a store, check latency, pulse width and busy release.
  task automatic do_write(input logic [9:0] a, input logic [31:0] d, input string tag);
    int c;
    mem_write = 1'b1; addr = a; wdata = d;
    tick();
    mem_write = 1'b0;
    chk({tag, "_busy_acc"}, busy, 1'b1);
    wait_ready(c);
    chk({tag, "_lat"}, c, 4);
    tick();
    chk({tag, "_ready_1cyc"}, ready, 1'b0);
    chk({tag, "_busy_rel"}, busy, 1'b0);
  endtask

  task automatic do_read(input logic [9:0] a, input logic [127:0] exp, input string tag);
    int c;
    mem_read = 1'b1; miss = 1'b1; addr = a;
    tick();
    mem_read = 1'b0; miss = 1'b0;
    wait_ready(c);
    chk({tag, "_lat"}, c, 4);
    chk({tag, "_blk"}, rdata_block, exp);
    tick();
    chk({tag, "_ready_1cyc"}, ready, 1'b0);
  endtask

  initial begin
    reset = 1'b0; mem_read = 1'b0; mem_write = 1'b0; miss = 1'b0;
    addr = '0; wdata = '0;
    tick(); tick();
    chk("rst_ready", ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_block", rdata_block, 128'h0);
    reset = 1'b1;
    tick();

    // T2 single store
    do_write(10'h085, 32'hDEADBEEF, "t2");

    // T3 preload and refill with non-zero offset
    do_write(10'h080, 32'h1, "pre80");
    do_write(10'h081, 32'h2, "pre81");
    do_write(10'h082, 32'h3, "pre82");
    do_write(10'h083, 32'h4, "pre83");
    do_read(10'h082, 128'h00000004_00000003_00000002_00000001, "t3");
    do_write(10'h084, 32'h11, "pre84");
    do_write(10'h086, 32'h22, "pre86");
    do_write(10'h087, 32'h33, "pre87");
    do_read(10'h087, 128'h00000033_00000022_DEADBEEF_00000011, "t2rd");

    // T4 cache hits are ignored
    mem_read = 1'b1; miss = 1'b0; addr = 10'h080;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_ready", ready, 1'b0);
      chk("t4_busy", busy, 1'b0);
    end
    mem_read = 1'b0;
    chk("t4_block", rdata_block, 128'h00000033_00000022_DEADBEEF_00000011);

    // T5 store wins over read miss; held request re-accepted only after DONE
    mem_read = 1'b1; miss = 1'b1; mem_write = 1'b1; addr = 10'h080; wdata = 32'hAAAA5555;
    tick();
    chk("t5_busy_acc", busy, 1'b1);
    wait_ready(n);
    chk("t5_lat", n, 4);
    chk("t5_no_refill", rdata_block, 128'h00000033_00000022_DEADBEEF_00000011);
    tick();
    chk("t5_done_ready", ready, 1'b0);
    chk("t5_done_busy", busy, 1'b0);
    tick();
    chk("t5_reacc_busy", busy, 1'b1);
    chk("t5_reacc_ready", ready, 1'b0);
    wait_ready(n);
    chk("t5_lat2", n, 4);
    mem_read = 1'b0; miss = 1'b0; mem_write = 1'b0;
    tick();
    chk("t5_ready_drop", ready, 1'b0);
    do_read(10'h081, 128'h00000004_00000003_00000002_AAAA5555, "t5rd");

    // T6 inputs change after acceptance
    do_write(10'h0C0, 32'hA0, "preC0");
    do_write(10'h0C1, 32'hA1, "preC1");
    do_write(10'h0C2, 32'hA2, "preC2");
    do_write(10'h0C3, 32'hA3, "preC3");
    mem_write = 1'b1; addr = 10'h0C1; wdata = 32'h12345678;
    tick();
    mem_write = 1'b0; addr = 10'h0C2; wdata = 32'hFFFFFFFF;
    wait_ready(n);
    chk("t6_lat", n, 4);
    tick();
    chk("t6_wr_no_refill", rdata_block, 128'h00000004_00000003_00000002_AAAA5555);
    do_read(10'h0C0, 128'h000000A3_000000A2_12345678_000000A0, "t6rd");

    // T1 reset during a store at cnt=2
    mem_write = 1'b1; addr = 10'h085; wdata = 32'hCAFEF00D;
    tick();
    mem_write = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    chk("t1_busy_now", busy, 1'b0);
    chk("t1_ready_now", ready, 1'b0);
    chk("t1_block_clr", rdata_block, 128'h0);
    tick(); tick();
    reset = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ready === 1'b1) n++;
    end
    chk("t1_no_ready", n, 0);
    do_read(10'h084, 128'h00000033_00000022_DEADBEEF_00000011, "t1rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
